// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired fetch/decode/execute control sequencer.
package control_sequencer_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned OPW  = 5;
    localparam int unsigned SELW = 4;
    localparam int unsigned IRW  = 32;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_RR, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST,
        CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    // Single-bit datapath strobes plus ALU code, as driven in one cycle.
    typedef struct packed {
        logic           pc_in;
        logic           pc_out;
        logic           inc_pc;
        logic           mar_in;
        logic           mdr_in;
        logic           mdr_out;
        logic           ir_in;
        logic           y_in;
        logic           z_in;
        logic           zlow_out;
        logic           zhigh_out;
        logic           hi_in;
        logic           lo_in;
        logic           c_out;
        logic           read;
        logic           write;
        logic           run;
        logic           illegal;
        logic [OPW-1:0] alu_op;
    } ctrl_t;

    function automatic op_class_e op_class(input logic [OPW-1:0] op);
        case (op)
            OP_LD:   return CLS_LD;
            OP_LDI:  return CLS_LDI;
            OP_ST:   return CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:  return CLS_RR;
            OP_ADDI, OP_ANDI, OP_ORI: return CLS_IMM;
            OP_MUL, OP_DIV:  return CLS_MULDIV;
            OP_NEG, OP_NOT:  return CLS_UNARY;
            OP_NOP:  return CLS_NOP;
            OP_HALT: return CLS_HALT;
            default: return CLS_ILLEGAL;
        endcase
    endfunction

    // Immediate forms reuse the base ALU function; address arithmetic is an add.
    function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] op);
        case (op)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
// The step input exists only when CONTROL_SEQUENCER_STEP_EN is defined.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [IRW-1:0]  ir;
    logic            mem_done;
`ifdef CONTROL_SEQUENCER_STEP_EN
    logic            step;
`endif
    logic [NREG-1:0] reg_in;
    logic [NREG-1:0] reg_out;
    logic            pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
    logic            y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out;
    logic            read, write;
    logic [OPW-1:0]  alu_op;
    logic            run;
    logic            illegal;

    modport master (
        input  ir,
        input  mem_done,
`ifdef CONTROL_SEQUENCER_STEP_EN
        input  step,
`endif
        output reg_in, reg_out,
        output pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
        output y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out,
        output read, write, alu_op, run, illegal
    );

    modport slave (
        output ir,
        output mem_done,
`ifdef CONTROL_SEQUENCER_STEP_EN
        output step,
`endif
        input  reg_in, reg_out,
        input  pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
        input  y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out,
        input  read, write, alu_op, run, illegal
    );

endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// Register-field to one-hot select decoder with enable.
module reg_select_decoder
    import control_sequencer_pkg::*;
(
    input  logic [SELW-1:0] sel,
    input  logic            en,
    output logic [NREG-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) onehot_c[sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute control sequencer driving the 32-bit bus datapath.
// Optional single-step parking in T0 enabled by CONTROL_SEQUENCER_STEP_EN.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    control_sequencer_if.master bus
);

    state_e          state_q, state_d;
    op_class_e       cls;
    ctrl_t           ctl_c;
    logic [OPW-1:0]  op;
    logic [SELW-1:0] ra, rb, rc;
    logic            ri_en_c, ro_en_c;
    logic [SELW-1:0] ro_sel_c;
    logic [NREG-1:0] reg_in_c, reg_out_c;
    logic            last_c;
    logic            park_c;
    logic            unused_ir_low;

    assign op  = bus.ir[OP_MSB:OP_LSB];
    assign ra  = bus.ir[RA_MSB:RA_LSB];
    assign rb  = bus.ir[RB_MSB:RB_LSB];
    assign rc  = bus.ir[RC_MSB:RC_LSB];
    assign cls = op_class(op);
    assign unused_ir_low = ^bus.ir[RC_LSB-1:0];

`ifdef CONTROL_SEQUENCER_STEP_EN
    logic parked_q, parked_d;

    // Park in T0 after each instruction until the operator steps.
    always_comb begin
        parked_d = parked_q;
        if (last_c)                    parked_d = 1'b1;
        else if (parked_q && bus.step) parked_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (clear) parked_q <= 1'b0;
        else       parked_q <= parked_d;
    end

    assign park_c = parked_q;
`else
    assign park_c = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) state_q <= ST_T0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ctl_c    = '0;
        ri_en_c  = 1'b0;
        ro_en_c  = 1'b0;
        ro_sel_c = rb;
        last_c   = 1'b0;
        // Every output is forced low while clear is held, whatever the state.
        if (!clear) begin
            ctl_c.run = (state_q != ST_HALT);
            case (state_q)
                ST_T0: begin
                    if (!park_c) begin
                        ctl_c.pc_out = 1'b1;
                        ctl_c.mar_in = 1'b1;
                        ctl_c.inc_pc = 1'b1;
                        ctl_c.z_in   = 1'b1;
                        state_d      = ST_T1;
                    end
                end
                ST_T1: begin
                    ctl_c.zlow_out = 1'b1;
                    ctl_c.pc_in    = 1'b1;
                    ctl_c.read     = 1'b1;
                    ctl_c.mdr_in   = 1'b1;
                    if (bus.mem_done) state_d = ST_T2;
                end
                ST_T2: begin
                    ctl_c.mdr_out = 1'b1;
                    ctl_c.ir_in   = 1'b1;
                    state_d       = ST_T3;
                end
                ST_T3: begin
                    case (cls)
                        CLS_NOP:     begin state_d = ST_T0; last_c = 1'b1; end
                        CLS_HALT:    state_d = ST_HALT;
                        CLS_ILLEGAL: begin ctl_c.illegal = 1'b1; state_d = ST_HALT; end
                        CLS_UNARY: begin
                            ro_en_c      = 1'b1;
                            ctl_c.alu_op = op;
                            ctl_c.z_in   = 1'b1;
                            state_d      = ST_T4;
                        end
                        CLS_MULDIV: begin
                            ro_en_c    = 1'b1;
                            ro_sel_c   = ra;
                            ctl_c.y_in = 1'b1;
                            state_d    = ST_T4;
                        end
                        default: begin
                            ro_en_c    = 1'b1;
                            ctl_c.y_in = 1'b1;
                            state_d    = ST_T4;
                        end
                    endcase
                end
                ST_T4: begin
                    case (cls)
                        CLS_RR, CLS_MULDIV: begin
                            ro_en_c      = 1'b1;
                            ro_sel_c     = (cls == CLS_RR) ? rc : rb;
                            ctl_c.alu_op = op;
                            ctl_c.z_in   = 1'b1;
                            state_d      = ST_T5;
                        end
                        CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                            ctl_c.c_out  = 1'b1;
                            ctl_c.alu_op = imm_alu_op(op);
                            ctl_c.z_in   = 1'b1;
                            state_d      = ST_T5;
                        end
                        CLS_UNARY: begin
                            ctl_c.zlow_out = 1'b1;
                            ri_en_c        = 1'b1;
                            state_d        = ST_T0;
                            last_c         = 1'b1;
                        end
                        default: state_d = ST_T0;
                    endcase
                end
                ST_T5: begin
                    ctl_c.zlow_out = 1'b1;
                    case (cls)
                        CLS_RR, CLS_IMM, CLS_LDI: begin
                            ri_en_c = 1'b1;
                            state_d = ST_T0;
                            last_c  = 1'b1;
                        end
                        CLS_MULDIV: begin ctl_c.lo_in  = 1'b1; state_d = ST_T6; end
                        CLS_LD, CLS_ST: begin ctl_c.mar_in = 1'b1; state_d = ST_T6; end
                        default: state_d = ST_T0;
                    endcase
                end
                ST_T6: begin
                    case (cls)
                        CLS_MULDIV: begin
                            ctl_c.zhigh_out = 1'b1;
                            ctl_c.hi_in     = 1'b1;
                            state_d         = ST_T0;
                            last_c          = 1'b1;
                        end
                        CLS_LD: begin
                            ctl_c.read   = 1'b1;
                            ctl_c.mdr_in = 1'b1;
                            if (bus.mem_done) state_d = ST_T7;
                        end
                        CLS_ST: begin
                            ro_en_c      = 1'b1;
                            ro_sel_c     = ra;
                            ctl_c.mdr_in = 1'b1;
                            state_d      = ST_T7;
                        end
                        default: state_d = ST_T0;
                    endcase
                end
                ST_T7: begin
                    case (cls)
                        CLS_LD: begin
                            ctl_c.mdr_out = 1'b1;
                            ri_en_c       = 1'b1;
                            state_d       = ST_T0;
                            last_c        = 1'b1;
                        end
                        CLS_ST: begin
                            ctl_c.write = 1'b1;
                            if (bus.mem_done) begin
                                state_d = ST_T0;
                                last_c  = 1'b1;
                            end
                        end
                        default: state_d = ST_T0;
                    endcase
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_T0;
            endcase
        end
    end

    reg_select_decoder u_reg_in_dec  (.sel(ra),       .en(ri_en_c), .onehot_c(reg_in_c));
    reg_select_decoder u_reg_out_dec (.sel(ro_sel_c), .en(ro_en_c), .onehot_c(reg_out_c));

    assign bus.reg_in    = reg_in_c;
    assign bus.reg_out   = reg_out_c;
    assign bus.pc_in     = ctl_c.pc_in;
    assign bus.pc_out    = ctl_c.pc_out;
    assign bus.inc_pc    = ctl_c.inc_pc;
    assign bus.mar_in    = ctl_c.mar_in;
    assign bus.mdr_in    = ctl_c.mdr_in;
    assign bus.mdr_out   = ctl_c.mdr_out;
    assign bus.ir_in     = ctl_c.ir_in;
    assign bus.y_in      = ctl_c.y_in;
    assign bus.z_in      = ctl_c.z_in;
    assign bus.zlow_out  = ctl_c.zlow_out;
    assign bus.zhigh_out = ctl_c.zhigh_out;
    assign bus.hi_in     = ctl_c.hi_in;
    assign bus.lo_in     = ctl_c.lo_in;
    assign bus.c_out     = ctl_c.c_out;
    assign bus.read      = ctl_c.read;
    assign bus.write     = ctl_c.write;
    assign bus.alu_op    = ctl_c.alu_op;
    assign bus.run       = ctl_c.run;
    assign bus.illegal   = ctl_c.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer; expected strobes are hand-derived per step.
module tb_control_sequencer;

    logic clock;
    logic clear;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    localparam logic [15:0] S_PC_IN  = 16'h0001;
    localparam logic [15:0] S_PC_OUT = 16'h0002;
    localparam logic [15:0] S_INC_PC = 16'h0004;
    localparam logic [15:0] S_MAR_IN = 16'h0008;
    localparam logic [15:0] S_MDR_IN = 16'h0010;
    localparam logic [15:0] S_MDR_OUT= 16'h0020;
    localparam logic [15:0] S_IR_IN  = 16'h0040;
    localparam logic [15:0] S_Y_IN   = 16'h0080;
    localparam logic [15:0] S_Z_IN   = 16'h0100;
    localparam logic [15:0] S_ZLOW   = 16'h0200;
    localparam logic [15:0] S_ZHIGH  = 16'h0400;
    localparam logic [15:0] S_HI_IN  = 16'h0800;
    localparam logic [15:0] S_LO_IN  = 16'h1000;
    localparam logic [15:0] S_C_OUT  = 16'h2000;
    localparam logic [15:0] S_READ   = 16'h4000;
    localparam logic [15:0] S_WRITE  = 16'h8000;

    localparam logic [15:0] F_T0 = S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN;
    localparam logic [15:0] F_T1 = S_ZLOW | S_PC_IN | S_READ | S_MDR_IN;
    localparam logic [15:0] F_T2 = S_MDR_OUT | S_IR_IN;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [15:0] strobes();
        return {bus.write, bus.read, bus.c_out, bus.lo_in, bus.hi_in, bus.zhigh_out,
                bus.zlow_out, bus.z_in, bus.y_in, bus.ir_in, bus.mdr_out, bus.mdr_in,
                bus.mar_in, bus.inc_pc, bus.pc_out, bus.pc_in};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] ri, input logic [15:0] ro,
                       input logic [15:0] sb, input logic [4:0] op,
                       input logic run, input logic ill);
        logic [54:0] o;
        logic [54:0] e;
        #1;
        o = {bus.reg_in, bus.reg_out, strobes(), bus.alu_op, bus.run, bus.illegal};
        e = {ri, ro, sb, op, run, ill};
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got ri=%h ro=%h sb=%h op=%b run=%b ill=%b, want ri=%h ro=%h sb=%h op=%b run=%b ill=%b",
                   tag, o[54:39], o[38:23], o[22:7], o[6:2], o[1], o[0],
                   e[54:39], e[38:23], e[22:7], e[6:2], e[1], e[0]);
        end
    endtask

    // Only meaningful in step builds: hold step low, confirm the park, then release it.
    task automatic park(input string tag);
`ifdef CONTROL_SEQUENCER_STEP_EN
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_park"}, 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
            tick();
        end
        bus.step = 1'b1;
        chk({tag, "_steppulse"}, 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0);
        tick();
        bus.step = 1'b0;
`else
        if (tag.len() == 0) tick();
`endif
    endtask

    task automatic fetch(input string tag);
        chk({tag, "_t0"}, 16'h0, 16'h0, F_T0, 5'b0, 1'b1, 1'b0);
        tick();
        chk({tag, "_t1"}, 16'h0, 16'h0, F_T1, 5'b0, 1'b1, 1'b0);
        tick();
        chk({tag, "_t2"}, 16'h0, 16'h0, F_T2, 5'b0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        clear        = 1'b1;
        bus.ir       = 32'h3000_0000;
        bus.mem_done = 1'b1;
`ifdef CONTROL_SEQUENCER_STEP_EN
        bus.step     = 1'b0;
`endif
        tick();
        tick();
        chk("clear", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);
        clear = 1'b0;

        // or R0,R0,R0 straight out of reset
        fetch("or0");
        chk("or0_t3", 16'h0, 16'h0001, S_Y_IN, 5'b0, 1'b1, 1'b0);   tick();
        chk("or0_t4", 16'h0, 16'h0001, S_Z_IN, 5'b00110, 1'b1, 1'b0); tick();
        chk("or0_t5", 16'h0001, 16'h0, S_ZLOW, 5'b0, 1'b1, 1'b0);   tick();

        // or R7,R4,R3
        bus.ir = mk_ir(5'b00110, 4'd7, 4'd4, 4'd3);
        park("or7");
        fetch("or7");
        chk("or7_t3", 16'h0, 16'h0010, S_Y_IN, 5'b0, 1'b1, 1'b0);   tick();
        chk("or7_t4", 16'h0, 16'h0008, S_Z_IN, 5'b00110, 1'b1, 1'b0); tick();
        chk("or7_t5", 16'h0080, 16'h0, S_ZLOW, 5'b0, 1'b1, 1'b0);   tick();

        // ld R2,(R1) with a three-cycle memory read
        bus.ir = mk_ir(5'b00000, 4'd2, 4'd1, 4'd0);
        park("ld");
        fetch("ld");
        chk("ld_t3", 16'h0, 16'h0002, S_Y_IN, 5'b0, 1'b1, 1'b0);             tick();
        chk("ld_t4", 16'h0, 16'h0, S_C_OUT | S_Z_IN, 5'b00011, 1'b1, 1'b0);  tick();
        bus.mem_done = 1'b0;
        chk("ld_t5", 16'h0, 16'h0, S_ZLOW | S_MAR_IN, 5'b0, 1'b1, 1'b0);     tick();
        chk("ld_t6a", 16'h0, 16'h0, S_READ | S_MDR_IN, 5'b0, 1'b1, 1'b0);    tick();
        chk("ld_t6b", 16'h0, 16'h0, S_READ | S_MDR_IN, 5'b0, 1'b1, 1'b0);    tick();
        bus.mem_done = 1'b1;
        chk("ld_t6c", 16'h0, 16'h0, S_READ | S_MDR_IN, 5'b0, 1'b1, 1'b0);    tick();
        chk("ld_t7", 16'h0004, 16'h0, S_MDR_OUT, 5'b0, 1'b1, 1'b0);          tick();

        // mul R5,R6
        bus.ir = mk_ir(5'b01111, 4'd5, 4'd6, 4'd0);
        park("mul");
        fetch("mul");
        chk("mul_t3", 16'h0, 16'h0020, S_Y_IN, 5'b0, 1'b1, 1'b0);       tick();
        chk("mul_t4", 16'h0, 16'h0040, S_Z_IN, 5'b01111, 1'b1, 1'b0);   tick();
        chk("mul_t5", 16'h0, 16'h0, S_ZLOW | S_LO_IN, 5'b0, 1'b1, 1'b0); tick();
        chk("mul_t6", 16'h0, 16'h0, S_ZHIGH | S_HI_IN, 5'b0, 1'b1, 1'b0); tick();

        // st R9,(R3) with a two-cycle write
        bus.ir = mk_ir(5'b00010, 4'd9, 4'd3, 4'd0);
        park("st");
        fetch("st");
        chk("st_t3", 16'h0, 16'h0008, S_Y_IN, 5'b0, 1'b1, 1'b0);            tick();
        chk("st_t4", 16'h0, 16'h0, S_C_OUT | S_Z_IN, 5'b00011, 1'b1, 1'b0); tick();
        bus.mem_done = 1'b0;
        chk("st_t5", 16'h0, 16'h0, S_ZLOW | S_MAR_IN, 5'b0, 1'b1, 1'b0);    tick();
        chk("st_t6", 16'h0, 16'h0200, S_MDR_IN, 5'b0, 1'b1, 1'b0);          tick();
        chk("st_t7a", 16'h0, 16'h0, S_WRITE, 5'b0, 1'b1, 1'b0);             tick();
        bus.mem_done = 1'b1;
        chk("st_t7b", 16'h0, 16'h0, S_WRITE, 5'b0, 1'b1, 1'b0);             tick();

        // andi R1,R2,#0
        bus.ir = mk_ir(5'b01101, 4'd1, 4'd2, 4'd0);
        park("andi");
        fetch("andi");
        chk("andi_t3", 16'h0, 16'h0004, S_Y_IN, 5'b0, 1'b1, 1'b0);            tick();
        chk("andi_t4", 16'h0, 16'h0, S_C_OUT | S_Z_IN, 5'b00101, 1'b1, 1'b0); tick();
        chk("andi_t5", 16'h0002, 16'h0, S_ZLOW, 5'b0, 1'b1, 1'b0);            tick();

        // neg R4,R8
        bus.ir = mk_ir(5'b10001, 4'd4, 4'd8, 4'd0);
        park("neg");
        fetch("neg");
        chk("neg_t3", 16'h0, 16'h0100, S_Z_IN, 5'b10001, 1'b1, 1'b0); tick();
        chk("neg_t4", 16'h0010, 16'h0, S_ZLOW, 5'b0, 1'b1, 1'b0);     tick();

        // nop
        bus.ir = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        park("nop");
        fetch("nop");
        chk("nop_t3", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0); tick();

        // halt, then clear while halted
        bus.ir = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        park("halt");
        fetch("halt");
        chk("halt_t3", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b0); tick();
        chk("halt_a", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);  tick();
        chk("halt_b", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);
        clear = 1'b1;
        chk("halt_clr", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0); tick();
        clear = 1'b0;

        // clear asserted during a T1 memory wait
        bus.ir = mk_ir(5'b11111, 4'd0, 4'd0, 4'd0);
        chk("wait_t0", 16'h0, 16'h0, F_T0, 5'b0, 1'b1, 1'b0); tick();
        bus.mem_done = 1'b0;
        chk("wait_t1a", 16'h0, 16'h0, F_T1, 5'b0, 1'b1, 1'b0); tick();
        chk("wait_t1b", 16'h0, 16'h0, F_T1, 5'b0, 1'b1, 1'b0);
        clear = 1'b1;
        chk("wait_clr", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0); tick();
        clear = 1'b0;
        bus.mem_done = 1'b1;

        // undefined opcode 11111
        fetch("ill");
        chk("ill_t3", 16'h0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b1);  tick();
        chk("ill_halt", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0); tick();
        chk("ill_halt2", 16'h0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ill_recover", 16'h0, 16'h0, F_T0, 5'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
